wshb_fb_slave: RTL and testbench
================================

WSHB_FB_SLAVE -- requirements
Module: wshb_fb_slave

Interface
REQ-001 Parameter DEPTH, default 1024: RAM size in 32-bit words; SHALL be a power of two.
REQ-002 Parameter INIT_VAL, default 32'h0000_0000: value of every word after elaboration.
REQ-003 Port clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port cyc  input  1: Wishbone cycle valid.
REQ-006 Port stb  input  1: Wishbone strobe.
REQ-007 Port we  input  1: write enable (1 = write, 0 = read).
REQ-008 Port adr  input  32: byte address; word index = adr[$clog2(DEPTH)+1:2].
REQ-009 Port dat_ms  input  32: write data, master to slave.
REQ-010 Port sel  input  4: byte enables; sel[i] qualifies dat_ms[8i+7:8i].
REQ-011 Port cti  input  3: cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
REQ-012 Port bte  input  2: burst type extension; only 00 (linear) is supported.
REQ-013 Port dat_sm  output  32: read data, slave to master.
REQ-014 Port ack  output  1: beat acknowledge.
REQ-015 Port err  output  1: beat error.
REQ-016 Port rty  output  1: retry; SHALL be tied to 0.

Function
REQ-017 Request = cyc & stb; beat completes on any cycle where request & (ack | err).
REQ-018 FSM states IDLE, CLASSIC, BURST; ack, err, dat_sm SHALL be registered.
REQ-019 IDLE: request with cti != 010 -> CLASSIC, ack=1 next cycle; request with cti == 010 -> BURST, ack=1 next cycle, ptr = word(adr)+1.
REQ-020 CLASSIC: ack SHALL be high exactly one cycle, then return to IDLE with ack=0 for at least one cycle (no double ack of one request).
REQ-021 BURST: while request & cti == 010, ack SHALL stay high every cycle (one beat per cycle), ptr incrementing by 1 per completed beat.
REQ-022 BURST: completed beat with cti == 111 -> IDLE, ack=0 next cycle.
REQ-023 BURST: request dropped (cyc or stb low) -> IDLE, ack=0 next cycle; prefetched data discarded; next request starts a new access from adr.
REQ-024 Read data: dat_sm presented with ack = mem[word(adr)] for the first beat, mem[ptr] for subsequent burst beats (predicted address, 1-cycle read latency).
REQ-025 Writes SHALL commit on the completing cycle using current adr, dat_ms, sel; bytes with sel[i]=0 unchanged.
REQ-026 ptr SHALL wrap modulo DEPTH (word DEPTH-1 followed by word 0).
REQ-027 Read of a word in the same cycle it is written SHALL return the old value (read-before-write).
REQ-028 Reads with we=0 SHALL not modify memory; dat_sm holds its last value when ack=0.

Reset
REQ-029 rst_n=0 sampled at clk: state=IDLE, ack=0, err=0, dat_sm=0, ptr=0; memory contents unchanged.
REQ-030 Reset mid-burst: ack SHALL be 0 on the cycle after rst_n is sampled low; no write commits on that cycle.

Configuration
REQ-031 Macro WSHB_FB_SLAVE_ERR_EN defined: access whose adr >= 4*DEPTH, or burst with bte != 00, SHALL get err=1 instead of ack (same timing), no write, dat_sm unchanged; erroring burst returns to IDLE after that beat.
REQ-032 Macro undefined: err tied 0; adr bits above the word index ignored (aliasing); bte ignored, all bursts linear.

Structure
REQ-033 Shared package wshb_pkg: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, BTE_LINEAR=2'b00, FSM state enum typedef.
REQ-034 Storage in sub-module fb_ram (1 read port, 1 write port with byte enables, registered read, read-before-write); FSM and ptr in wshb_fb_slave.

Verification
REQ-035 Classic write adr=0x10, dat_ms=0xDEADBEEF, sel=1111 then classic read adr=0x10 -> ack 1 cycle after each request, dat_sm=0xDEADBEEF, ack low between.
REQ-036 Partial write sel=0010, dat_ms=0x0000AB00 over 0x11223344 at adr=0x20 -> subsequent read returns 0x1122AB44.
REQ-037 Burst read of 8 beats from adr=0x0, words preloaded 0..7, cti=010 for 7 beats then 111 -> ack high 8 consecutive cycles, dat_sm=0,1,...,7, ack=0 following cycle.
REQ-038 Burst started at word DEPTH-2 for 4 beats -> data words DEPTH-2, DEPTH-1, 0, 1.
REQ-039 stb dropped after beat 3 of a burst, reasserted 2 cycles later with adr=0xC -> new access, first ack 1 cycle after reassertion, dat_sm=mem[3].
REQ-040 rst_n low mid-burst -> ack=0 next cycle; with WSHB_FB_SLAVE_ERR_EN, read adr=4*DEPTH -> err=1 one cycle later, ack=0.

Source files
------------

// File: rtl/wshb_pkg.sv
// Shared Wishbone constants and the slave FSM state type.
package wshb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/fb_ram.sv
// Word RAM: one registered read port, one byte-enabled write port,
// read-before-write on a same-cycle address collision.
module fb_ram #(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               wbe_i
);

    logic [31:0] mem_q [DEPTH] = '{default: INIT_VAL};
    logic [31:0] rdata_q;

    // Output register clears on reset; the array itself never does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wshb_fb_slave.sv
// Wishbone registered-feedback RAM slave with linear burst prefetch.
// Define WSHB_FB_SLAVE_ERR_EN to flag out-of-range / non-linear accesses.
module wshb_fb_slave
    import wshb_pkg::*;
#(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    input  logic [3:0]  sel,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] dat_sm,
    output logic        ack,
    output logic        err,
    output logic        rty
);

    localparam int AW = $clog2(DEPTH);

    fsm_state_e    state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] word, raddr;
    logic          req, re, wr_en;
    logic          in_range, bad_first, bad_next;
    logic          unused;

    assign req  = cyc & stb;
    assign word = adr[AW+1:2];

`ifdef WSHB_FB_SLAVE_ERR_EN
    assign unused    = ^adr[1:0];
    assign in_range  = (adr[31:AW+2] == '0);
    assign bad_first = !in_range ||
                       ((cti == CTI_INCR) && (bte != BTE_LINEAR));
    // ptr of zero mid-burst means the next beat runs past the top
    assign bad_next  = (ptr_q == '0) || (bte != BTE_LINEAR);
`else
    assign unused    = ^{adr[31:AW+2], adr[1:0], bte};
    assign in_range  = 1'b1;
    assign bad_first = 1'b0;
    assign bad_next  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        raddr   = word;
        re      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad_first) begin
                        err_d   = 1'b1;
                        state_d = ST_CLASSIC;
                    end else begin
                        ack_d   = 1'b1;
                        re      = 1'b1;
                        ptr_d   = word + AW'(1);
                        state_d = (cti == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                    end
                end
            end
            ST_CLASSIC: state_d = ST_IDLE;
            ST_BURST: begin
                state_d = ST_IDLE;
                if (req && (cti == CTI_INCR)) begin
                    if (bad_next) begin
                        err_d   = 1'b1;
                        state_d = ST_CLASSIC;
                    end else begin
                        ack_d   = 1'b1;
                        re      = 1'b1;
                        raddr   = ptr_q;
                        ptr_d   = ptr_q + AW'(1);
                        state_d = ST_BURST;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    // A beat's write lands on the cycle the master sees its ack.
    assign wr_en = rst_n & req & we & ack_q & in_range;

    fb_ram #(
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (dat_sm),
        .we_i    (wr_en),
        .waddr_i (word),
        .wdata_i (dat_ms),
        .wbe_i   (sel)
    );

    assign ack = ack_q;
    assign err = err_q;
    assign rty = 1'b0;

endmodule

// File: tb/tb_wshb_fb_slave.sv
// Self-checking bench for wshb_fb_slave: vector table, corner sequences,
// and random traffic against an array model of the memory.
module tb_wshb_fb_slave;
    import wshb_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] INIT  = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack, err, rty;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [DEPTH];

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    wshb_fb_slave #(.DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we),
        .adr(adr), .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte),
        .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cyc = 0; stb = 0; we = 0; adr = '0; dat_ms = '0;
        sel = '0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    endtask

    task automatic classic(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd);
        int wd;
        wd = int'(a[$clog2(DEPTH)+1:2]);
        cyc = 1; stb = 1; we = w; adr = a; dat_ms = d;
        sel = s; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        tick();
        chk("classic_ack", 32'(ack), 32'd1);
        chk("classic_err", 32'(err), 32'd0);
        rd = dat_sm;
        tick();
        if (w) mdl[wd] = merge(mdl[wd], d, s);
        idle_bus();
        chk("classic_ack_drop", 32'(ack), 32'd0);
    endtask

    task automatic burst(input int start, input int n, input logic w,
                         input logic rnd, input logic [31:0] hi,
                         input logic [1:0] b);
        int          wd;
        logic [31:0] d [8];
        logic [3:0]  s [8];
        for (int i = 0; i < n; i++) begin
            d[i] = rnd ? 32'($urandom) : 32'((start + i) % DEPTH);
            s[i] = rnd ? 4'($urandom) : 4'hF;
        end
        cyc = 1; stb = 1; we = w; bte = b;
        adr = hi | 32'((start % DEPTH) * 4);
        dat_ms = d[0]; sel = s[0];
        cti = (n == 1) ? CTI_EOB : CTI_INCR;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i > 0) begin
                wd = (start + i - 1) % DEPTH;
                if (w) mdl[wd] = merge(mdl[wd], d[i-1], s[i-1]);
                adr = hi | 32'(((start + i) % DEPTH) * 4);
                dat_ms = d[i]; sel = s[i];
                cti = (i == n - 1) ? CTI_EOB : CTI_INCR;
            end
            chk("burst_ack", 32'(ack), 32'd1);
            if (!w) chk("burst_data", dat_sm, mdl[(start + i) % DEPTH]);
        end
        tick();
        wd = (start + n - 1) % DEPTH;
        if (w) mdl[wd] = merge(mdl[wd], d[n-1], s[n-1]);
        idle_bus();
        chk("burst_ack_end", 32'(ack), 32'd0);
    endtask

`ifdef WSHB_FB_SLAVE_ERR_EN
    task automatic err_access(input logic w, input logic [31:0] a,
                              input logic [2:0] c, input logic [1:0] b);
        logic [31:0] hold;
        hold = dat_sm;
        cyc = 1; stb = 1; we = w; adr = a; dat_ms = 32'hFFFF_FFFF;
        sel = 4'hF; cti = c; bte = b;
        tick();
        chk("err_flag", 32'(err), 32'd1);
        chk("err_noack", 32'(ack), 32'd0);
        chk("err_dat_hold", dat_sm, hold);
        tick();
        idle_bus();
        chk("err_clear", 32'(err), 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp;
        logic [31:0] hi;
        int          kind, n, st, wd;

        for (int i = 0; i < DEPTH; i++) mdl[i] = INIT;
        tbl[0] = '{"wr_full",    1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[1] = '{"rd_full",    1'b0, 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF};
        tbl[2] = '{"wr_base",    1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0};
        tbl[3] = '{"wr_byte1",   1'b1, 32'h20, 32'h0000_AB00, 4'h2, 32'h0};
        tbl[4] = '{"rd_partial", 1'b0, 32'h20, 32'h0,         4'hF, 32'h1122_AB44};
        tbl[5] = '{"rd_init",    1'b0, 32'h30, 32'h0,         4'hF, 32'hA5A5_5A5A};
        tbl[6] = '{"wr_b30",     1'b1, 32'h30, 32'hAABB_CCDD, 4'h9, 32'h0};
        tbl[7] = '{"rd_b30",     1'b0, 32'h30, 32'h0,         4'hF, 32'hAAA5_5ADD};

        rst_n = 0;
        idle_bus();
        tick();
        tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rty", 32'(rty), 32'd0);
        chk("rst_dat", dat_sm, 32'd0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 8; i++) begin
            classic(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, rd);
            if (!tbl[i].w) chk(tbl[i].name, rd, tbl[i].exp);
        end
        tick();
        tick();
        chk("dat_hold", dat_sm, 32'hAAA5_5ADD);

        // 8-beat write then 8-beat read of words 0..7
        burst(0, 8, 1'b1, 1'b0, 32'h0, BTE_LINEAR);
        burst(0, 8, 1'b0, 1'b0, 32'h0, BTE_LINEAR);

        // master drops stb after beat 3, then a fresh classic read
        cyc = 1; stb = 1; we = 0; bte = BTE_LINEAR;
        cti = CTI_INCR; adr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            adr = 32'(i * 4);
            chk("drop_ack", 32'(ack), 32'd1);
            chk("drop_data", dat_sm, mdl[i]);
        end
        tick();
        stb = 0;
        tick();
        chk("drop_ack_low", 32'(ack), 32'd0);
        tick();
        chk("drop_ack_low2", 32'(ack), 32'd0);
        stb = 1; adr = 32'hC; cti = CTI_CLASSIC;
        tick();
        chk("restart_ack", 32'(ack), 32'd1);
        chk("restart_data", dat_sm, mdl[3]);
        tick();
        idle_bus();
        chk("restart_ack_drop", 32'(ack), 32'd0);

        // reset lands on a completing write beat of a burst
        cyc = 1; stb = 1; we = 1; sel = 4'hF; bte = BTE_LINEAR;
        cti = CTI_INCR; adr = 32'(8 * 4); dat_ms = 32'h1111_0008;
        tick();
        chk("rstb_ack0", 32'(ack), 32'd1);
        tick();
        mdl[8] = 32'h1111_0008;
        adr = 32'(9 * 4); dat_ms = 32'h1111_0009;
        chk("rstb_ack1", 32'(ack), 32'd1);
        tick();
        mdl[9] = 32'h1111_0009;
        adr = 32'(10 * 4); dat_ms = 32'h1111_000A;
        rst_n = 0;
        chk("rstb_ack2", 32'(ack), 32'd1);
        tick();
        chk("rstb_ack_low", 32'(ack), 32'd0);
        chk("rstb_dat", dat_sm, 32'd0);
        rst_n = 1;
        idle_bus();
        tick();
        exp = mdl[10];
        classic(1'b0, 32'(10 * 4), 32'h0, 4'hF, rd);
        chk("rstb_nowrite", rd, exp);
        classic(1'b0, 32'(9 * 4), 32'h0, 4'hF, rd);
        chk("rstb_beat1", rd, 32'h1111_0009);

`ifndef WSHB_FB_SLAVE_ERR_EN
        // wrap across the top of memory
        for (int k = 0; k < 4; k++) begin
            wd = (DEPTH - 2 + k) % DEPTH;
            classic(1'b1, 32'(wd * 4), 32'h1000 + 32'(k), 4'hF, rd);
        end
        burst(DEPTH - 2, 4, 1'b0, 1'b0, 32'h0, BTE_LINEAR);
        chk("wrap_word0", mdl[0], 32'h1002);
`else
        err_access(1'b0, 32'(4 * DEPTH), CTI_CLASSIC, BTE_LINEAR);
        exp = mdl[0];
        err_access(1'b1, 32'(4 * DEPTH), CTI_CLASSIC, BTE_LINEAR);
        classic(1'b0, 32'h0, 32'h0, 4'hF, rd);
        chk("err_nowrite", rd, exp);
        err_access(1'b0, 32'h0, CTI_INCR, 2'b01);
`endif

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 6);
`ifdef WSHB_FB_SLAVE_ERR_EN
            hi = 32'h0;
            st = $urandom_range(0, DEPTH - n);
`else
            hi = 32'($urandom) & ~32'(4 * DEPTH - 1);
            st = $urandom_range(0, DEPTH - 1);
`endif
            case (kind)
                0: classic(1'b1, hi | 32'(st * 4), 32'($urandom),
                           4'($urandom), rd);
                1: begin
                    exp = mdl[st];
                    classic(1'b0, hi | 32'(st * 4), 32'h0, 4'hF, rd);
                    chk("rand_read", rd, exp);
                end
                2: burst(st, n, 1'b0, 1'b1, hi, BTE_LINEAR);
                default: burst(st, n, 1'b1, 1'b1, hi, BTE_LINEAR);
            endcase
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
